fifo_wr_arbiter: RTL

//  Round-robin burst arbiter that shares the single write port of the async FIFO among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter that shares the write port of an async FIFO
//   among NUM_REQ producers. It runs only in the FIFO write-clock domain.
//   A grant lasts for up to BURST_LEN beats. Priority then rotates to the
//   next requester after the last one granted. There is one idle cycle
//   between bursts.
//   Optional feature macro: FIFO_ARB_STATS_EN adds per-requester beat
//   counters, a stall counter, and a synchronous clear input.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int Data_Width = 8,
   parameter int BURST_LEN  = 4,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*Data_Width-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          wr_en,
   output logic [Data_Width-1:0]         data_in,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic                          stat_clr,
   output logic [NUM_REQ*16-1:0]         stat_beats,
   output logic [15:0]                   stat_stall
`endif
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic                  beat;
   logic                  pick_found;
   logic [ID_W-1:0]       pick_idx;
   logic [ID_W-1:0]       cand_idx;
   logic [Data_Width-1:0] req_data_arr [NUM_REQ];

   // Unpack the flat data bus so the granted lane can be selected by index.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_data_arr[gi] = req_data[gi*Data_Width +: Data_Width];
      end
   endgenerate

   // Beat qualification and write-port outputs. Everything is zero unless a
   // beat actually moves, so full can never let a write through.
   always_comb begin
      beat      = (state_q == BURST) && req_valid[grant_q] && !full;
      wr_en     = beat;
      req_ready = '0;
      data_in   = '0;
      if (beat) begin
         req_ready[grant_q] = 1'b1;
         data_in            = req_data_arr[grant_q];
      end
   end

   // Round-robin pick: the first valid requester after last_q, wrapping modulo NUM_REQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand_idx = ID_W'((int'(last_q) + i) % NUM_REQ);
         if (!pick_found && req_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Next-state logic for the IDLE/BURST controller.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (!req_valid[grant_q]) begin
               // The requester gave up its slot, so the rest of the burst is forfeited.
               state_d = IDLE;
            end else if (beat) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                  state_d = IDLE;
               end
            end
            // full with valid asserted: hold everything (stall)
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller registers. last_q starts at NUM_REQ-1 so requester 0 wins first.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stall_q, stall_d;
   logic        stall_cycle;

   assign stall_cycle = (state_q == BURST) && full && req_valid[grant_q];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
         logic [15:0] beats_q, beats_d;

         // Saturating per-requester accepted-beat counter. A clear takes priority over an increment.
         always_comb begin
            beats_d = beats_q;
            if (stat_clr) begin
               beats_d = '0;
            end else if (beat && (grant_q == ID_W'(gi)) && (beats_q != 16'hFFFF)) begin
               beats_d = beats_q + 16'd1;
            end
         end

         // Beat counter register.
         always_ff @(posedge wr_clk or posedge wr_rst) begin
            if (wr_rst) begin
               beats_q <= '0;
            end else begin
               beats_q <= beats_d;
            end
         end

         assign stat_beats[gi*16 +: 16] = beats_q;
      end
   endgenerate

   // Saturating stall counter: counts BURST cycles blocked only by full.
   always_comb begin
      stall_d = stall_q;
      if (stat_clr) begin
         stall_d = '0;
      end else if (stall_cycle && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stat_stall = stall_q;
`endif

endmodule
